// File: rtl/pc_fetch_unit.sv
// Instruction fetch sequencer: one outstanding request, single-entry output hold, redirect drain.
// Optional misaligned-target trap enabled by defining FETCH_ALIGN_CHECK_EN.
module pc_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [63:0] NextPC,
  input  logic        Redirect,
  output logic        IMemReq,
  output logic [63:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [63:0] InstrPC,
  input  logic        InstrReady,
  output logic        FetchFault
);

  localparam logic [2:0] StStart = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StDrain = 3'd2;
  localparam logic [2:0] StHold  = 3'd3;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [2:0] StFault = 3'd4;
`endif

  logic [2:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] pend_q, pend_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] instr_pc_q, instr_pc_d;
  logic        load_en;
  logic [63:0] load_tgt;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    load_en    = 1'b0;
    load_tgt   = NextPC;
    case (state_q)
      StStart: state_d = StFetch;
      StFetch: begin
        if (IMemAck) begin
          if (Redirect) begin
            load_en = 1'b1;
          end else begin
            instr_d    = IMemData;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 64'd4;
            state_d    = StHold;
          end
        end else if (Redirect) begin
          pend_d  = NextPC;
          state_d = StDrain;
        end
      end
      StDrain: begin
        // The in-flight response is dropped; a same-cycle redirect beats the pending target.
        if (IMemAck) begin
          load_en  = 1'b1;
          load_tgt = Redirect ? NextPC : pend_q;
        end else if (Redirect) begin
          pend_d = NextPC;
        end
      end
      StHold: begin
        if (Redirect) begin
          load_en = 1'b1;
        end else if (InstrReady) begin
          state_d = StFetch;
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      StFault: state_d = StFault;
`endif
      default: state_d = StStart;
    endcase

    if (load_en) begin
`ifdef FETCH_ALIGN_CHECK_EN
      if (load_tgt[1:0] != 2'b00) begin
        state_d = StFault;
      end else begin
        pc_d    = load_tgt;
        state_d = StFetch;
      end
`else
      pc_d    = load_tgt;
      state_d = StFetch;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= StStart;
      pc_q       <= RESET_PC;
      pend_q     <= 64'h0;
      instr_q    <= 32'h0;
      instr_pc_q <= 64'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign IMemReq    = (state_q == StFetch) || (state_q == StDrain);
  assign IMemAddr   = pc_q;
  assign InstrValid = (state_q == StHold);
  assign Instr      = instr_q;
  assign InstrPC    = instr_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign FetchFault = (state_q == StFault);
`else
  assign FetchFault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic against a
// transaction-level model (request in flight / held instruction / discard pending).
module tb_pc_fetch_unit;

  localparam logic [63:0] RST = 64'h100;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [63:0] NextPC = 64'h0;
  logic        Redirect = 1'b0;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic        IMemAck = 1'b0;
  logic [31:0] IMemData = 32'h0;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [63:0] InstrPC;
  logic        InstrReady = 1'b0;
  logic        FetchFault;

  int n_pass = 0;
  int n_total = 0;

  // Model: a request is in flight (m_busy), possibly to be discarded (m_kill),
  // or one instruction is waiting for decode (m_held).
  logic        m_start = 1'b0, m_busy = 1'b0, m_kill = 1'b0, m_held = 1'b0;
  logic [63:0] m_pc = 64'h0, m_tgt = 64'h0, m_ipc = 64'h0;
  logic [31:0] m_instr = 32'h0;

  pc_fetch_unit #(.RESET_PC(RST)) dut (
    .CLK(CLK), .Reset(Reset), .NextPC(NextPC), .Redirect(Redirect),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemData(IMemData),
    .InstrValid(InstrValid), .Instr(Instr), .InstrPC(InstrPC),
    .InstrReady(InstrReady), .FetchFault(FetchFault)
  );

  always #5 CLK = ~CLK;

  task automatic model_step(input logic rst, input logic ack, input logic redir,
                            input logic [63:0] npc, input logic ready, input logic [31:0] data);
    if (rst) begin
      m_start = 1'b1; m_busy = 1'b0; m_kill = 1'b0; m_held = 1'b0;
      m_pc = RST; m_tgt = 64'h0; m_ipc = 64'h0; m_instr = 32'h0;
    end else if (m_start) begin
      m_start = 1'b0; m_busy = 1'b1;
    end else if (m_busy) begin
      if (ack) begin
        if (m_kill) begin
          m_pc = redir ? npc : m_tgt; m_kill = 1'b0;
        end else if (redir) begin
          m_pc = npc;
        end else begin
          m_held = 1'b1; m_busy = 1'b0; m_instr = data; m_ipc = m_pc; m_pc = m_pc + 64'd4;
        end
      end else if (redir) begin
        m_kill = 1'b1; m_tgt = npc;
      end
    end else if (m_held) begin
      if (redir) begin
        m_held = 1'b0; m_busy = 1'b1; m_pc = npc;
      end else if (ready) begin
        m_held = 1'b0; m_busy = 1'b1;
      end
    end
  endtask

  // Apply inputs for one cycle, then land 1 time unit after the edge.
  task automatic drive(input logic rst, input logic ack, input logic redir,
                       input logic [63:0] npc, input logic ready, input logic [31:0] data);
    Reset = rst; IMemAck = ack; Redirect = redir; NextPC = npc; InstrReady = ready;
    IMemData = data;
    model_step(rst, ack, redir, npc, ready, data);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 64'h0, 1'b1, 32'hdead_beef);
    n_total++; if (IMemReq !== 1'b0) $display("FAIL reset_req got=%b exp=0", IMemReq); else n_pass++;
    n_total++; if (InstrValid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", InstrValid); else n_pass++;
    n_total++; if (Instr !== 32'h0) $display("FAIL reset_instr got=%h exp=0", Instr); else n_pass++;
    n_total++; if (InstrPC !== 64'h0) $display("FAIL reset_ipc got=%h exp=0", InstrPC); else n_pass++;
    n_total++; if (FetchFault !== 1'b0) $display("FAIL reset_fault got=%b exp=0", FetchFault); else n_pass++;
  endtask

  // Ack one cycle after each request, decode always ready.
  task automatic test_sequential;
    logic [31:0] d;
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 32'h0);
    for (int k = 0; k < 3; k++) begin
      d = 32'h1000_0000 + 32'(k);
      n_total++;
      if (IMemReq !== 1'b1 || IMemAddr !== RST + 64'(4 * k))
        $display("FAIL seq_addr%0d got=%b/%h exp=1/%h", k, IMemReq, IMemAddr, RST + 64'(4 * k));
      else n_pass++;
      drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, d);
      n_total++;
      if (InstrValid !== 1'b1 || InstrPC !== RST + 64'(4 * k) || Instr !== d)
        $display("FAIL seq_capture%0d got=%b/%h/%h exp=1/%h/%h", k, InstrValid, InstrPC, Instr,
                 RST + 64'(4 * k), d);
      else n_pass++;
      drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 32'h0);
    end
  endtask

  task automatic test_hold_stall;
    drive(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 32'hcafe_0001);
    for (int k = 0; k < 5; k++) begin
      n_total++;
      if (InstrValid !== 1'b1 || Instr !== 32'hcafe_0001 || InstrPC !== 64'h10c || IMemReq !== 1'b0)
        $display("FAIL hold_stall%0d got=%b/%h/%h/%b exp=1/cafe0001/10c/0", k, InstrValid, Instr,
                 InstrPC, IMemReq);
      else n_pass++;
      drive(1'b0, k[0], 1'b0, 64'h0, 1'b0, 32'hbad0_0000);
    end
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 32'h0);
    n_total++;
    if (InstrValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 64'h110)
      $display("FAIL hold_release got=%b/%b/%h exp=0/1/110", InstrValid, IMemReq, IMemAddr);
    else n_pass++;
  endtask

  task automatic test_drain_redirect;
    drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 32'h0);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 32'h2000_0000 + 32'(k));
      drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 32'h0);
    end
    drive(1'b0, 1'b0, 1'b1, 64'h400, 1'b1, 32'h0);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (IMemReq !== 1'b1 || IMemAddr !== 64'h108 || InstrValid !== 1'b0)
        $display("FAIL drain_hold%0d got=%b/%h/%b exp=1/108/0", k, IMemReq, IMemAddr, InstrValid);
      else n_pass++;
      drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 32'h0);
    end
    drive(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 32'hbad0_0108);
    n_total++;
    if (IMemReq !== 1'b1 || IMemAddr !== 64'h400 || InstrValid !== 1'b0 || InstrPC !== 64'h104)
      $display("FAIL drain_retarget got=%b/%h/%b/%h exp=1/400/0/104", IMemReq, IMemAddr,
               InstrValid, InstrPC);
    else n_pass++;
  endtask

  task automatic test_hold_redirect;
    drive(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 32'h4000_0000);
    n_total++;
    if (InstrValid !== 1'b1 || InstrPC !== 64'h400)
      $display("FAIL hredir_hold got=%b/%h exp=1/400", InstrValid, InstrPC);
    else n_pass++;
    drive(1'b0, 1'b0, 1'b1, 64'h200, 1'b1, 32'h0);
    n_total++;
    if (InstrValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 64'h200)
      $display("FAIL hredir_flush got=%b/%b/%h exp=0/1/200", InstrValid, IMemReq, IMemAddr);
    else n_pass++;
  endtask

  task automatic test_misaligned;
    drive(1'b0, 1'b1, 1'b1, 64'h202, 1'b1, 32'h0);
    for (int k = 0; k < 3; k++) begin
`ifdef FETCH_ALIGN_CHECK_EN
      n_total++;
      if (FetchFault !== 1'b1 || IMemReq !== 1'b0 || InstrValid !== 1'b0)
        $display("FAIL misalign_fault%0d got=%b/%b/%b exp=1/0/0", k, FetchFault, IMemReq, InstrValid);
      else n_pass++;
`else
      n_total++;
      if (FetchFault !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 64'h202)
        $display("FAIL misalign_use%0d got=%b/%b/%h exp=0/1/202", k, FetchFault, IMemReq, IMemAddr);
      else n_pass++;
`endif
      drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 32'h0);
    end
  endtask

  task automatic test_reset_in_drain;
    drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 64'h800, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    n_total++;
    if (IMemReq !== 1'b0 || InstrValid !== 1'b0 || Instr !== 32'h0 || InstrPC !== 64'h0)
      $display("FAIL rst_drain_start got=%b/%b/%h/%h exp=0/0/0/0", IMemReq, InstrValid, Instr, InstrPC);
    else n_pass++;
    drive(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 32'hbad0_0800);
    n_total++;
    if (IMemReq !== 1'b1 || IMemAddr !== RST || InstrValid !== 1'b0)
      $display("FAIL rst_drain_first got=%b/%h/%b exp=1/%h/0", IMemReq, IMemAddr, InstrValid, RST);
    else n_pass++;
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 32'h0);
    n_total++;
    if (InstrValid !== 1'b0 || IMemAddr !== RST)
      $display("FAIL rst_drain_wait got=%b/%h exp=0/%h", InstrValid, IMemAddr, RST);
    else n_pass++;
    drive(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 32'h5555_aaaa);
    n_total++;
    if (InstrValid !== 1'b1 || Instr !== 32'h5555_aaaa || InstrPC !== RST)
      $display("FAIL rst_drain_done got=%b/%h/%h exp=1/5555aaaa/%h", InstrValid, Instr, InstrPC, RST);
    else n_pass++;
  endtask

  // Zero-wait memory with decode always ready: one instruction per two cycles.
  task automatic test_back_to_back;
    drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 32'h0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 32'h7000_0000 + 32'(k));
      n_total++;
      if (InstrValid !== 1'b1 || InstrPC !== RST + 64'(4 * k))
        $display("FAIL b2b_instr%0d got=%b/%h exp=1/%h", k, InstrValid, InstrPC, RST + 64'(4 * k));
      else n_pass++;
      drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 32'h0);
    end
  endtask

  task automatic test_random;
    logic        rst, ack, redir, ready;
    logic [63:0] npc;
    drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    for (int c = 0; c < 600; c++) begin
      n_total++;
      if (IMemReq !== m_busy) $display("FAIL rnd_req c=%0d got=%b exp=%b", c, IMemReq, m_busy);
      else n_pass++;
      if (m_busy) begin
        n_total++;
        if (IMemAddr !== m_pc) $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, IMemAddr, m_pc);
        else n_pass++;
      end
      n_total++;
      if (InstrValid !== m_held) $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, InstrValid, m_held);
      else n_pass++;
      n_total++;
      if (Instr !== m_instr || InstrPC !== m_ipc)
        $display("FAIL rnd_instr c=%0d got=%h/%h exp=%h/%h", c, Instr, InstrPC, m_instr, m_ipc);
      else n_pass++;
      n_total++;
      if (FetchFault !== 1'b0) $display("FAIL rnd_fault c=%0d got=%b exp=0", c, FetchFault);
      else n_pass++;
      rst   = ($urandom_range(0, 99) < 2);
      ack   = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      redir = ($urandom_range(0, 6) == 0);
      ready = ($urandom_range(0, 4) < 3);
      npc   = {32'h0, $urandom} & 64'hffff_fffc;
      drive(rst, ack, redir, npc, ready, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold_stall();
    test_drain_redirect();
    test_hold_redirect();
    test_misaligned();
    test_reset_in_drain();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
